uart_rx: RTL and testbench

//   Serial UART receiver: 8N1 framing, 16x oversampling, internal baud-tick divider.

---
 rtl/uart_rx_if.sv | 24 ++
 rtl/uart_rx.sv | 128 ++++++++++++
 tb/tb_uart_rx.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial receive bundle: line input plus the received-byte and status pulses.
// master is the receiver, slave is the consumer that also drives the line.
interface uart_rx_if #(
    parameter int DBIT = 8
);
    logic            rx;
    logic [DBIT-1:0] d_out;
    logic            rx_done;
    logic            framing_error;

    modport master (
        input  rx,
        output d_out,
        output rx_done,
        output framing_error
    );

    modport slave (
        output rx,
        input  d_out,
        input  rx_done,
        input  framing_error
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampling from a free-running tick divider.
// Emits one-cycle rx_done with the byte, or framing_error on a low stop bit.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DIVISOR = 326
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_if.master      bus
);
    localparam int TW = $clog2(DIVISOR);
    localparam int SW = $clog2(SB_TICK > 16 ? SB_TICK : 16);
    localparam int NW = $clog2(DBIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]   s_cnt_q, s_cnt_d;
    logic [NW-1:0]   n_cnt_q, n_cnt_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
    logic            rx_s;
    logic            tick;

    assign rx_s = sync_q[1];
    assign tick = (tick_cnt_q == TW'(DIVISOR - 1));

    always_comb begin
        sync_d     = {sync_q[0], bus.rx};
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        state_d    = state_q;
        s_cnt_d    = s_cnt_q;
        n_cnt_d    = n_cnt_q;
        shift_d    = shift_q;
        dout_d     = dout_q;
        done_d     = 1'b0;
        ferr_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end
            START: begin
                if (tick) begin
                    // mid start bit: a high line here was only a glitch
                    if (s_cnt_q == SW'(7)) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            n_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_cnt_q == SW'(15)) begin
                        shift_d = {rx_s, shift_q[DBIT-1:1]};
                        s_cnt_d = '0;
                        if (n_cnt_q == NW'(DBIT - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_cnt_d = n_cnt_q + 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    // leave at mid stop bit so a back-to-back start edge is seen
                    if (s_cnt_q == SW'(SB_TICK - 1)) begin
                        if (rx_s) begin
                            dout_d = shift_q;
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                        state_d = IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sync_q     <= 2'b11;
            tick_cnt_q <= '0;
            s_cnt_q    <= '0;
            n_cnt_q    <= '0;
            shift_q    <= '0;
            dout_q     <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            tick_cnt_q <= tick_cnt_d;
            s_cnt_q    <= s_cnt_d;
            n_cnt_q    <= n_cnt_d;
            shift_q    <= shift_d;
            dout_q     <= dout_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
        end
    end

    assign bus.d_out         = dout_q;
    assign bus.rx_done       = done_q;
    assign bus.framing_error = ferr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIVISOR=4 (one bit = 64 clk).
// A negedge monitor logs bytes, pulse timing and error pulses.
module tb_uart_rx;
    logic clk = 1'b0;
    logic reset = 1'b1;

    uart_rx_if #(.DBIT(8)) bus ();

    uart_rx #(
        .DBIT(8),
        .SB_TICK(16),
        .DIVISOR(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int fe_cnt = 0;
    int wide_cnt = 0;
    int both_cnt = 0;
    int last_done_cyc = 0;
    int prev_done_cyc = 0;
    logic prev_done = 1'b0;
    logic prev_fe = 1'b0;
    logic [7:0] got_q[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.rx_done) begin
            done_cnt <= done_cnt + 1;
            got_q.push_back(bus.d_out);
            prev_done_cyc <= last_done_cyc;
            last_done_cyc <= cyc;
        end
        if (bus.framing_error) fe_cnt <= fe_cnt + 1;
        if ((bus.rx_done && prev_done) || (bus.framing_error && prev_fe))
            wide_cnt <= wide_cnt + 1;
        if (bus.rx_done && bus.framing_error) both_cnt <= both_cnt + 1;
        prev_done <= bus.rx_done;
        prev_fe   <= bus.framing_error;
    end

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // stop_clk < per gives a short low stop bit for framing-error tests
    task automatic send(input logic [7:0] b, input int per,
                        input int stop_lvl, input int stop_clk);
        bus.rx = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (per) @(negedge clk);
        end
        bus.rx = stop_lvl[0];
        repeat (stop_clk) @(negedge clk);
        bus.rx = 1'b1;
    endtask

    task automatic pop(input string tag, input logic [7:0] exp);
        logic [7:0] v;
        v = 8'hxx;
        if (got_q.size() > 0) v = got_q.pop_front();
        check(tag, v, exp);
    endtask

    int d0, f0, gap;

    initial begin
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dout", bus.d_out, 0);
        check("rst_done", bus.rx_done, 0);
        check("rst_fe", bus.framing_error, 0);
        reset = 1'b0;
        idle(17);

        // 1: single frame
        send(8'h01, 64, 1, 64);
        idle(40);
        check("t1_cnt", done_cnt, 1);
        pop("t1_byte", 8'h01);
        check("t1_dout", bus.d_out, 8'h01);
        check("t1_fe", fe_cnt, 0);

        // 2: back-to-back frames
        send(8'hA5, 64, 1, 64);
        send(8'h3C, 64, 1, 64);
        idle(40);
        check("t2_cnt", done_cnt, 3);
        pop("t2_b0", 8'hA5);
        pop("t2_b1", 8'h3C);
        gap = last_done_cyc - prev_done_cyc;
        check("t2_gap", (gap >= 632 && gap <= 648), 1);

        // 3: start-bit glitch
        d0 = done_cnt;
        f0 = fe_cnt;
        bus.rx = 1'b0;
        repeat (20) @(negedge clk);
        idle(200);
        check("t3_done", done_cnt, d0);
        check("t3_fe", fe_cnt, f0);

        // 4: good frame then low stop bit
        send(8'h02, 64, 1, 64);
        idle(30);
        send(8'h55, 64, 0, 40);
        idle(300);
        check("t4_done", done_cnt, d0 + 1);
        check("t4_fe", fe_cnt, f0 + 1);
        pop("t4_byte", 8'h02);
        check("t4_dout", bus.d_out, 8'h02);

        // 5: reset during data bit 3
        d0 = done_cnt;
        fork
            send(8'hFF, 64, 1, 64);
            begin
                repeat (64 * 4 + 32) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        join
        idle(50);
        send(8'h04, 64, 1, 64);
        idle(40);
        check("t5_done", done_cnt, d0 + 1);
        pop("t5_byte", 8'h04);
        check("t5_dout", bus.d_out, 8'h04);

        // 6: baud tolerance +/-3%
        d0 = done_cnt;
        f0 = fe_cnt;
        send(8'h00, 66, 1, 66); idle(20);
        send(8'hFF, 66, 1, 66); idle(20);
        send(8'h80, 66, 1, 66); idle(20);
        send(8'h00, 62, 1, 62); idle(20);
        send(8'hFF, 62, 1, 62); idle(20);
        send(8'h80, 62, 1, 62); idle(40);
        check("t6_done", done_cnt, d0 + 6);
        check("t6_fe", fe_cnt, f0);
        pop("t6_s0", 8'h00);
        pop("t6_s1", 8'hFF);
        pop("t6_s2", 8'h80);
        pop("t6_f0", 8'h00);
        pop("t6_f1", 8'hFF);
        pop("t6_f2", 8'h80);

        check("pulse_width", wide_cnt, 0);
        check("exclusive", both_cnt, 0);
        check("leftover", got_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
